// File: rtl/doa_dsp_pkg.sv
// Shared Q-format constants and data types for the pointwise DoA scaling stages.
package doa_dsp_pkg;

    localparam int DIN_WIDTH  = 18;
    localparam int W_WIDTH    = 16;
    localparam int W_FRAC     = 15;
    localparam int DOUT_WIDTH = 18;
    localparam int PROD_WIDTH = DIN_WIDTH + W_WIDTH;

    localparam logic signed [DOUT_WIDTH-1:0] SAT_MAX = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic signed [DOUT_WIDTH-1:0] SAT_MIN = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

    typedef logic signed [DIN_WIDTH-1:0]  sample_t;
    typedef logic signed [W_WIDTH-1:0]    weight_t;
    typedef logic signed [PROD_WIDTH-1:0] prod_t;
    typedef logic signed [DOUT_WIDTH-1:0] dout_t;

endpackage

// File: rtl/shift_round_sat.sv
// Arithmetic right shift by FRAC with saturation to OUT_WIDTH.
// Macro WEIGHT_ROUND_EN: add half an LSB before the shift (round half up); otherwise truncate toward -inf.
module shift_round_sat #(
    parameter int IN_WIDTH  = doa_dsp_pkg::PROD_WIDTH,
    parameter int OUT_WIDTH = doa_dsp_pkg::DOUT_WIDTH,
    parameter int FRAC      = doa_dsp_pkg::W_FRAC
) (
    input  logic signed [IN_WIDTH-1:0]  din,
    output logic signed [OUT_WIDTH-1:0] dout
);

    // One guard bit so the rounding add can never wrap.
    localparam logic signed [IN_WIDTH:0] MAXV =
        {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [IN_WIDTH:0] MINV = ~MAXV;

    logic signed [IN_WIDTH:0] ext;
    logic signed [IN_WIDTH:0] shifted;

`ifdef WEIGHT_ROUND_EN
    localparam logic signed [IN_WIDTH:0] HALF = signed'({{IN_WIDTH{1'b0}}, 1'b1} << (FRAC-1));
    assign ext = {din[IN_WIDTH-1], din} + HALF;
`else
    assign ext = {din[IN_WIDTH-1], din};
`endif

    assign shifted = ext >>> FRAC;

    always_comb begin
        dout = shifted[OUT_WIDTH-1:0];
        if (shifted > MAXV) begin
            dout = MAXV[OUT_WIDTH-1:0];
        end else if (shifted < MINV) begin
            dout = MINV[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/rom_weight_apply.sv
// Per-channel weight stage: drives the coefficient ROM from a sync-locked channel counter and
// applies the returned weight with a 3-stage multiply/scale pipeline. Build macro: WEIGHT_ROUND_EN.
module rom_weight_apply
    import doa_dsp_pkg::*;
#(
    parameter  int N_ADDR = 256,
    localparam int AW     = $clog2(N_ADDR)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [DIN_WIDTH-1:0]  din,
    input  logic                         din_valid,
    input  logic                         sync_in,
    output logic                         rom_ren,
    output logic [AW-1:0]                rom_radd,
    input  logic signed [W_WIDTH-1:0]    rom_wout,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         dout_valid,
    output logic                         sync_out,
    output logic                         frame_err
);

    logic [AW-1:0] cnt;
    logic [AW-1:0] addr;
    logic [AW-1:0] cnt_next;
    logic          v1, v2, v3;
    logic          s1, s2, s3;
    sample_t       d1;
    prod_t         prod;
    dout_t         scaled;

    // A qualified sync forces address 0 in the same cycle it arrives.
    assign addr     = sync_in ? '0 : cnt;
    assign cnt_next = (addr == AW'(N_ADDR-1)) ? '0 : addr + AW'(1);
    assign rom_ren  = din_valid;
    assign rom_radd = addr;

    shift_round_sat #(
        .IN_WIDTH (PROD_WIDTH),
        .OUT_WIDTH(DOUT_WIDTH),
        .FRAC     (W_FRAC)
    ) u_scale (
        .din (prod),
        .dout(scaled)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            d1        <= '0;
            prod      <= '0;
            dout      <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= din_valid && sync_in && (cnt != '0);
            v1        <= din_valid;
            s1        <= din_valid && sync_in;
            if (din_valid) begin
                d1  <= din;
                cnt <= cnt_next;
            end
            // ROM data for the S1 sample arrives in this cycle.
            v2 <= v1;
            s2 <= s1;
            if (v1) begin
                prod <= prod_t'(d1) * prod_t'(rom_wout);
            end
            v3 <= v2;
            s3 <= s2;
            if (v2) begin
                dout <= scaled;
            end
        end
    end

    assign dout_valid = v3;
    assign sync_out   = s3;

endmodule

// File: tb/tb_rom_weight_apply.sv
// Directed bench for rom_weight_apply with a 1-cycle-latency ROM model and per-cycle expectations.
module tb_rom_weight_apply;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [17:0] din = '0;
    logic               din_valid = 1'b0;
    logic               sync_in = 1'b0;
    logic               rom_ren;
    logic [7:0]         rom_radd;
    logic signed [15:0] rom_wout = '0;
    logic signed [17:0] dout;
    logic               dout_valid;
    logic               sync_out;
    logic               frame_err;

    logic signed [15:0] rom_mem [0:255];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_d = 0;
    bit exp_v  [0:2047];
    bit exp_s  [0:2047];
    bit exp_fe [0:2047];
    int exp_d  [0:2047];

    rom_weight_apply dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .sync_in   (sync_in),
        .rom_ren   (rom_ren),
        .rom_radd  (rom_radd),
        .rom_wout  (rom_wout),
        .dout      (dout),
        .dout_valid(dout_valid),
        .sync_out  (sync_out),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (rom_ren) rom_wout <= rom_mem[rom_radd];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cycle %0d observed %0d expected %0d", tag, cyc, $signed(obs), $signed(expv));
        end
    endtask

    task automatic check_outputs();
        chk("dout_valid", 32'(dout_valid), 32'(exp_v[cyc]));
        chk("sync_out", 32'(sync_out), 32'(exp_s[cyc]));
        chk("frame_err", 32'(frame_err), 32'(exp_fe[cyc]));
        if (exp_v[cyc]) last_d = exp_d[cyc];
        chk("dout", 32'(dout), last_d);
    endtask

    task automatic step(input bit v, input bit s, input int d, input int a, input int e, input bit fe);
        din_valid = v;
        sync_in   = s;
        din       = 18'(d);
        if (v) begin
            exp_v[cyc+3]  = 1'b1;
            exp_s[cyc+3]  = s;
            exp_d[cyc+3]  = e;
            exp_fe[cyc+1] = fe;
        end
        @(negedge clk);
        check_outputs();
        chk("rom_ren", 32'(rom_ren), 32'(v));
        if (v) chk("rom_radd", 32'(rom_radd), a);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic rst_cycle();
        rst_n     = 1'b0;
        din_valid = 1'b0;
        sync_in   = 1'b0;
        @(negedge clk);
        check_outputs();
        for (int k = 1; k <= 3; k++) begin
            exp_v[cyc+k] = 1'b0;
            exp_s[cyc+k] = 1'b0;
        end
        exp_fe[cyc+1] = 1'b0;
        last_d = 0;
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
    endtask

    task automatic fill_rom(input int w);
        for (int i = 0; i < 256; i++) rom_mem[i] = 16'(w);
    endtask

    initial begin
        int r_pos, r_neg;
`ifdef WEIGHT_ROUND_EN
        r_pos = 2;
        r_neg = -1;
`else
        r_pos = 1;
        r_neg = -2;
`endif
        for (int i = 0; i < 2048; i++) begin
            exp_v[i] = 1'b0; exp_s[i] = 1'b0; exp_fe[i] = 1'b0; exp_d[i] = 0;
        end
        fill_rom(16'h4000);

        // Outputs are unknown before the first reset edge; check from the second reset cycle on.
        @(posedge clk);
        #1;
        cyc = 1;
        rst_cycle();

        // Full frame at weight 0.5, sync on channel 0.
        for (int i = 0; i < 256; i++) step(1'b1, i == 0, 1000, i, 500, 1'b0);

        // Valid gap pattern 1,0,0,1 after the wrap; dout holds through the gap.
        step(1'b1, 1'b0, 1000, 0, 500, 1'b0);
        idle(2);
        step(1'b1, 1'b0, 1000, 1, 500, 1'b0);
        idle(4);

        // Early sync at channel 10; an unqualified sync is ignored.
        for (int i = 2; i < 10; i++) step(1'b1, 1'b0, 1000, i, 500, 1'b0);
        step(1'b0, 1'b1, 0, 0, 0, 1'b0);
        step(1'b1, 1'b1, 1000, 0, 500, 1'b1);
        step(1'b1, 1'b0, 1000, 1, 500, 1'b0);
        step(1'b1, 1'b0, 1000, 2, 500, 1'b0);
        idle(4);

        // Saturation and rounding corners.
        rom_mem[0] = -16'sd32768;
        rom_mem[1] = 16'sd32767;
        rom_mem[2] = 16'sh4000;
        rom_mem[3] = 16'sh4000;
        rom_mem[4] = 16'sd32767;
        rst_cycle();
        step(1'b1, 1'b1, -131072, 0, 131071, 1'b0);
        step(1'b1, 1'b0, 131071, 1, 131067, 1'b0);
        step(1'b1, 1'b0, 3, 2, r_pos, 1'b0);
        step(1'b1, 1'b0, -3, 3, r_neg, 1'b0);
        step(1'b1, 1'b0, -131072, 4, -131068, 1'b0);
        idle(4);

        // Reset mid-frame with the pipe full.
        fill_rom(16'h4000);
        rst_cycle();
        for (int i = 0; i < 100; i++) step(1'b1, i == 0, 1000, i, 500, 1'b0);
        rst_cycle();
        step(1'b1, 1'b0, 2000, 0, 1000, 1'b0);
        step(1'b1, 1'b0, 2000, 1, 1000, 1'b0);
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
